// File: rtl/alu_div16_if.sv
// rtl/alu_div16_if.sv - start/done handshake and operand/result bundle for alu_div16
interface alu_div16_if #(
    parameter int WIDTH = 16
);
    logic             start;
    logic [WIDTH-1:0] dividend;
    logic [WIDTH-1:0] divisor;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] quotient;
    logic [WIDTH-1:0] remainder;
    logic             div_by_zero;

    modport master (
        output start, dividend, divisor,
        input  busy, done, quotient, remainder, div_by_zero
    );

    modport slave (
        input  start, dividend, divisor,
        output busy, done, quotient, remainder, div_by_zero
    );
endinterface

// File: rtl/alu_div16.sv
// rtl/alu_div16.sv - multi-cycle unsigned restoring divider, one quotient bit per clock
module alu_div16 #(
    parameter int WIDTH = 16
) (
    input  logic      clk,
    input  logic      rst_n,
    alu_div16_if.slave bus
);
    localparam int CNT_W = (WIDTH > 2) ? $clog2(WIDTH) : 1;

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t           state;
    logic [CNT_W-1:0] cnt;
    logic [WIDTH-1:0] q_sh;
    logic [WIDTH-1:0] dvsr;
    // Partial remainder stays below the divisor between iterations, so its
    // extra headroom bit only exists inside the W+1-bit trial below.
    logic [WIDTH-1:0] prem;
    logic             busy_r;
    logic             done_r;
    logic [WIDTH-1:0] quot_r;
    logic [WIDTH-1:0] rem_r;
    logic             dbz_r;

    logic [WIDTH:0]   shifted;
    logic [WIDTH:0]   trial;
    logic             q_bit;
    logic [WIDTH-1:0] rem_next;
    logic [WIDTH-1:0] q_next;

    assign shifted  = {prem, q_sh[WIDTH-1]};
    assign trial    = shifted - {1'b0, dvsr};
    assign q_bit    = ~trial[WIDTH];
    assign rem_next = q_bit ? trial[WIDTH-1:0] : shifted[WIDTH-1:0];
    assign q_next   = {q_sh[WIDTH-2:0], q_bit};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= IDLE;
            cnt    <= '0;
            q_sh   <= '0;
            dvsr   <= '0;
            prem   <= '0;
            busy_r <= 1'b0;
            done_r <= 1'b0;
            quot_r <= '0;
            rem_r  <= '0;
            dbz_r  <= 1'b0;
        end else begin
            case (state)
                IDLE, DONE: begin
                    done_r <= 1'b0;
                    state  <= IDLE;
                    if (bus.start) begin
                        q_sh <= bus.dividend;
                        dvsr <= bus.divisor;
                        prem <= '0;
                        if (bus.divisor == '0) begin
                            // Zero divisor completes immediately with the saturated result.
                            state  <= DONE;
                            done_r <= 1'b1;
                            cnt    <= '0;
                            quot_r <= '1;
                            rem_r  <= bus.dividend;
                            dbz_r  <= 1'b1;
                        end else begin
                            state  <= RUN;
                            busy_r <= 1'b1;
                            cnt    <= CNT_W'(WIDTH - 1);
                        end
                    end
                end
                RUN: begin
                    prem <= rem_next;
                    q_sh <= q_next;
                    cnt  <= cnt - 1'b1;
                    if (cnt == '0) begin
                        state  <= DONE;
                        busy_r <= 1'b0;
                        done_r <= 1'b1;
                        quot_r <= q_next;
                        rem_r  <= rem_next;
                        dbz_r  <= 1'b0;
                    end
                end
                default: begin
                    state  <= IDLE;
                    busy_r <= 1'b0;
                    done_r <= 1'b0;
                end
            endcase
        end
    end

    assign bus.busy        = busy_r;
    assign bus.done        = done_r;
    assign bus.quotient    = quot_r;
    assign bus.remainder   = rem_r;
    assign bus.div_by_zero = dbz_r;
endmodule

// File: tb/tb_alu_div16.sv
// tb/tb_alu_div16.sv - table-driven and sequence checks for alu_div16
module tb_alu_div16;
    logic clk = 1'b0;
    logic rst_n = 1'b0;

    alu_div16_if #(.WIDTH(16)) bus ();

    alu_div16 #(.WIDTH(16)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    typedef struct {
        string       nm;
        logic [15:0] dd;
        logic [15:0] dv;
        logic [15:0] eq;
        logic [15:0] er;
        logic        ed;
        int          elat;
        int          ebusy;
    } vec_t;

    vec_t vecs[9];

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
        end
    endtask

    // Counts negedges until done (bounded); busy cycles and busy&done overlap recorded.
    task automatic wait_done(output int lat, output int bc, output bit both);
        lat = 0;
        bc = 0;
        both = 1'b0;
        for (int n = 1; n <= 40; n++) begin
            @(negedge clk);
            if (bus.busy) bc++;
            if (bus.busy && bus.done) both = 1'b1;
            if (bus.done) begin
                lat = n;
                break;
            end
        end
    endtask

    task automatic run_op(input vec_t v);
        int lat;
        int bc;
        bit both;
        bus.dividend = v.dd;
        bus.divisor  = v.dv;
        bus.start    = 1'b1;
        @(posedge clk);
        #1 bus.start = 1'b0;
        wait_done(lat, bc, both);
        check({v.nm, " latency"}, lat, v.elat);
        check({v.nm, " busy_cycles"}, bc, v.ebusy);
        check({v.nm, " busy_and_done"}, {31'd0, both}, 32'd0);
        check({v.nm, " quotient"}, bus.quotient, v.eq);
        check({v.nm, " remainder"}, bus.remainder, v.er);
        check({v.nm, " div_by_zero"}, bus.div_by_zero, v.ed);
        @(negedge clk);
        check({v.nm, " done_drops"}, bus.done, 1'b0);
        check({v.nm, " quotient_held"}, bus.quotient, v.eq);
    endtask

    initial begin
        int lat;
        int bc;
        bit both;
        bit saw_done;

        vecs[0] = '{"100/7",      16'd100,    16'd7,      16'd14,     16'd2,  1'b0, 17, 16};
        vecs[1] = '{"ffff/1",     16'hFFFF,   16'd1,      16'hFFFF,   16'd0,  1'b0, 17, 16};
        vecs[2] = '{"ffff/ffff",  16'hFFFF,   16'hFFFF,   16'd1,      16'd0,  1'b0, 17, 16};
        vecs[3] = '{"3/10",       16'd3,      16'd10,     16'd0,      16'd3,  1'b0, 17, 16};
        vecs[4] = '{"0/5",        16'd0,      16'd5,      16'd0,      16'd0,  1'b0, 17, 16};
        vecs[5] = '{"5/0",        16'd5,      16'd0,      16'hFFFF,   16'd5,  1'b1, 1,  0};
        vecs[6] = '{"9/3",        16'd9,      16'd3,      16'd3,      16'd0,  1'b0, 17, 16};
        vecs[7] = '{"1000/3",     16'd1000,   16'd3,      16'd333,    16'd1,  1'b0, 17, 16};
        vecs[8] = '{"8000/3",     16'h8000,   16'd3,      16'd10922,  16'd2,  1'b0, 17, 16};

        bus.start    = 1'b0;
        bus.dividend = '0;
        bus.divisor  = '0;

        #1;
        check("reset busy", bus.busy, 1'b0);
        check("reset done", bus.done, 1'b0);
        check("reset quotient", bus.quotient, 16'd0);
        check("reset remainder", bus.remainder, 16'd0);
        check("reset div_by_zero", bus.div_by_zero, 1'b0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        for (int i = 0; i < 9; i++) run_op(vecs[i]);

        // start pulsed mid-run must neither restart nor resample operands
        bus.dividend = 16'd100;
        bus.divisor  = 16'd7;
        bus.start    = 1'b1;
        @(posedge clk);
        #1 bus.start = 1'b0;
        repeat (4) @(negedge clk);
        check("run shows previous quotient", bus.quotient, 16'd10922);
        check("run shows previous remainder", bus.remainder, 16'd2);
        bus.dividend = 16'd50;
        bus.divisor  = 16'd5;
        bus.start    = 1'b1;
        @(posedge clk);
        #1 bus.start = 1'b0;
        wait_done(lat, bc, both);
        check("ignored start latency", lat, 13);
        check("ignored start quotient", bus.quotient, 16'd14);
        check("ignored start remainder", bus.remainder, 16'd2);

        // back-to-back accept in the done cycle, no bubble
        bus.dividend = 16'd50;
        bus.divisor  = 16'd5;
        bus.start    = 1'b1;
        @(posedge clk);
        #1 bus.start = 1'b0;
        @(negedge clk);
        check("b2b busy rises", bus.busy, 1'b1);
        check("b2b done drops", bus.done, 1'b0);
        wait_done(lat, bc, both);
        check("b2b latency", lat, 16);
        check("b2b quotient", bus.quotient, 16'd10);
        check("b2b remainder", bus.remainder, 16'd0);
        @(negedge clk);

        // asynchronous reset in the middle of a run
        bus.dividend = 16'd1000;
        bus.divisor  = 16'd3;
        bus.start    = 1'b1;
        @(posedge clk);
        #1 bus.start = 1'b0;
        repeat (8) @(negedge clk);
        check("pre-reset busy", bus.busy, 1'b1);
        rst_n = 1'b0;
        #1;
        check("mid reset busy", bus.busy, 1'b0);
        check("mid reset done", bus.done, 1'b0);
        check("mid reset quotient", bus.quotient, 16'd0);
        check("mid reset remainder", bus.remainder, 16'd0);
        check("mid reset div_by_zero", bus.div_by_zero, 1'b0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        saw_done = 1'b0;
        repeat (20) begin
            @(negedge clk);
            if (bus.done || bus.busy) saw_done = 1'b1;
        end
        check("no activity after reset", {31'd0, saw_done}, 32'd0);
        run_op(vecs[7]);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1, "timeout");
    end
endmodule
